// File: rtl/ssd_mux_driver_pkg.sv
// ssd_defs: shared definitions for the multiplexed seven-segment driver.
//   SEG_BLANK    - all segments and DP dark (active-low)
//   scan_state_e - scan FSM encodings (blank / drive part of a digit slot)
//   SEG_HEX      - active-low segment patterns for hex digits 0..F
//   hex_to_seg   - lookup helper for SEG_HEX
package ssd_defs;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    localparam logic [7:0] SEG_HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
        return SEG_HEX[v];
    endfunction

endpackage

// File: rtl/ssd_scan_timer.sv
// ssd_scan_timer: slot/digit/frame timing for the multiplexed display.
//   clk, rst      - clock, synchronous active-high reset
//   slot_start    - high while the slot counter is 0 (snapshot point)
//   drive         - high while the scan FSM is in the drive part of a slot
//   frame_wrap    - pulse on the cycle where the digit index wraps to 0
//   idx           - digit currently being scanned
//   blink_phase   - toggles every BLINK_DIV frames; 1 = blinking digits dark
module ssd_scan_timer #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_DIV    = 64,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             slot_start,
    output logic             drive,
    output logic             frame_wrap,
    output logic [IDX_W-1:0] idx,
    output logic             blink_phase
);
    import ssd_defs::*;

    localparam int S_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int F_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [S_W-1:0]   s_q, s_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [F_W-1:0]   frame_q, frame_d;
    logic             phase_q, phase_d;
    logic             slot_wrap;
    scan_state_e      state_q, state_d;

    always_comb begin
        slot_wrap  = (s_q == S_W'(CLK_DIV - 1));
        s_d        = slot_wrap ? '0 : s_q + 1'b1;
        idx_d      = idx_q;
        frame_d    = frame_q;
        phase_d    = phase_q;
        frame_wrap = 1'b0;
        if (slot_wrap) begin
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                // with a single digit every slot wrap is also a frame wrap
                idx_d      = '0;
                frame_wrap = 1'b1;
                if (frame_q == F_W'(BLINK_DIV - 1)) begin
                    frame_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    frame_d = frame_q + 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // state tracks the slot counter: it is DRIVE exactly when s >= BLANK_CYCLES
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (int'(s_d) >= BLANK_CYCLES) state_d = ST_DRIVE;
            ST_DRIVE: if (slot_wrap && BLANK_CYCLES > 0) state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
            state_q <= ST_BLANK;
        end else begin
            s_q     <= s_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            state_q <= state_d;
        end
    end

    assign slot_start  = (s_q == '0);
    assign drive       = (state_q == ST_DRIVE);
    assign idx         = idx_q;
    assign blink_phase = phase_q;

endmodule

// File: rtl/ssd_mux_driver.sv
// ssd_mux_driver: time-multiplexed seven-segment display driver with
// anti-ghosting blanking, per-digit enable/blink and PWM brightness.
//   clk, rst    - clock, synchronous active-high reset
//   digits      - active-low segment patterns, digit 0 in bits [7:0]
//   digit_en    - per-digit enable (0 = dark)
//   blink_en    - per-digit blink enable (sampled at slot start)
//   brightness  - duty level 0..15, duty = (brightness+1)/16
//   cathode     - registered active-low segments + DP
//   anode       - registered active-low digit selects
module ssd_mux_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_DIV    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic [3:0]              brightness,
    output logic [7:0]              cathode,
    output logic [NUM_DIGITS-1:0]   anode
);
    import ssd_defs::*;

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic             slot_start;
    logic             drive;
    logic             unused_frame_wrap;
    logic             blink_phase;
    logic [IDX_W-1:0] idx;

    logic [3:0]            pwm_q;
    logic [7:0]            seg_q;
    logic                  blink_sel_q;
    logic [7:0]            cathode_d;
    logic [NUM_DIGITS-1:0] anode_d;

    ssd_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .CLK_DIV     (CLK_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .BLINK_DIV   (BLINK_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .slot_start (slot_start),
        .drive      (drive),
        .frame_wrap (unused_frame_wrap),
        .idx        (idx),
        .blink_phase(blink_phase)
    );

    // only one anode bit can ever be cleared, so at most one digit is lit
    always_comb begin
        anode_d   = '1;
        cathode_d = SEG_BLANK;
        if (drive) begin
            cathode_d = seg_q;
            if (digit_en[idx] && !(blink_sel_q && blink_phase) && (pwm_q <= brightness))
                anode_d[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anode       <= '1;
            cathode     <= SEG_BLANK;
            pwm_q       <= '0;
            seg_q       <= SEG_BLANK;
            blink_sel_q <= 1'b0;
        end else begin
            anode   <= anode_d;
            cathode <= cathode_d;
            pwm_q   <= pwm_q + 1'b1;
            // pattern and blink enable are frozen for the whole slot
            if (slot_start) begin
                seg_q       <= digits[{idx, 3'b000} +: 8];
                blink_sel_q <= blink_en[idx];
            end
        end
    end

endmodule

// File: tb/tb_ssd_mux_driver.sv
module tb_ssd_mux_driver;
    localparam int ND = 4;
    localparam int CD = 8;
    localparam int BC = 2;
    localparam int BD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] digits = 32'hC0F9A4B0;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  blink_en = 4'h0;
    logic [3:0]  brightness = 4'd15;
    logic [7:0]  cathode;
    logic [3:0]  anode;

    int total = 0;
    int bad = 0;
    int cur = -1;

    always #5 clk = ~clk;

    ssd_mux_driver #(
        .NUM_DIGITS  (ND),
        .CLK_DIV     (CD),
        .BLANK_CYCLES(BC),
        .BLINK_DIV   (BD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits    (digits),
        .digit_en  (digit_en),
        .blink_en  (blink_en),
        .brightness(brightness),
        .cathode   (cathode),
        .anode     (anode)
    );

    typedef struct {
        logic [3:0] an;
        logic [7:0] cat;
    } exp_t;

    typedef struct {
        logic [31:0] dg;
        logic [3:0]  den;
        logic [3:0]  ben;
        logic [3:0]  br;
        int          cyc;
        logic [3:0]  an;
        logic [7:0]  cat;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[$];

    // reference model: expected pins for each edge, pushed at the edge
    initial begin : model
        int unsigned m_s, m_idx, m_frame;
        logic        m_phase, m_blk;
        logic [3:0]  m_pwm;
        logic [7:0]  m_seg;
        exp_t        e;
        m_s = 0; m_idx = 0; m_frame = 0; m_phase = 0; m_blk = 0; m_pwm = 0; m_seg = 8'hFF;
        forever begin
            @(posedge clk);
            e.an  = 4'b1111;
            e.cat = 8'hFF;
            if (rst) begin
                m_s = 0; m_idx = 0; m_frame = 0; m_phase = 0; m_pwm = 0; m_blk = 0; m_seg = 8'hFF;
            end else begin
                if (m_s == 0) begin
                    m_seg = digits[8*m_idx +: 8];
                    m_blk = blink_en[m_idx];
                end
                if (m_s >= BC) begin
                    e.cat = m_seg;
                    if (digit_en[m_idx] && !(m_blk && m_phase) && m_pwm <= brightness)
                        e.an[m_idx] = 1'b0;
                end
                m_pwm = m_pwm + 4'd1;
                if (m_s == CD - 1) begin
                    m_s = 0;
                    if (m_idx == ND - 1) begin
                        m_idx = 0;
                        if (m_frame == BD - 1) begin
                            m_frame = 0;
                            m_phase = ~m_phase;
                        end else begin
                            m_frame++;
                        end
                    end else begin
                        m_idx++;
                    end
                end else begin
                    m_s++;
                end
            end
            sbq.push_back(e);
        end
    end

    // scoreboard: compare pins on the falling edge after each push
    initial begin : scoreboard
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                total++;
                if (anode !== e.an || cathode !== e.cat) begin
                    bad++;
                    $display("FAIL sb t=%0t anode=%b cathode=%h, expected anode=%b cathode=%h",
                             $time, anode, cathode, e.an, e.cat);
                end
                total++;
                if (!$onehot0(~anode)) begin
                    bad++;
                    $display("FAIL onehot t=%0t anode=%b has more than one low bit", $time, anode);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cur = -1;
    endtask

    task automatic step_to(input int c);
        while (cur < c) begin
            step();
            cur++;
        end
    endtask

    task automatic chk(input string nm, input logic [3:0] an_e, input logic [7:0] cat_e);
        total++;
        if (anode !== an_e || cathode !== cat_e) begin
            bad++;
            $display("FAIL %s: anode=%b cathode=%h, expected anode=%b cathode=%h",
                     nm, anode, cathode, an_e, cat_e);
        end
    endtask

    task automatic addv(input logic [31:0] dg, input logic [3:0] den, input logic [3:0] ben,
                        input logic [3:0] br, input int cyc, input logic [3:0] an,
                        input logic [7:0] cat);
        vec_t v;
        v.dg = dg; v.den = den; v.ben = ben; v.br = br; v.cyc = cyc; v.an = an; v.cat = cat;
        tbl.push_back(v);
    endtask

    localparam logic [31:0] DG = 32'hC0F9A4B0;

    initial begin
        // cycle c = pins after the c-th edge following reset release
        addv(DG, 4'hF, 4'h0, 4'd15,   0, 4'b1111, 8'hFF);
        addv(DG, 4'hF, 4'h0, 4'd15,   1, 4'b1111, 8'hFF);
        addv(DG, 4'hF, 4'h0, 4'd15,   2, 4'b1110, 8'hB0);
        addv(DG, 4'hF, 4'h0, 4'd15,   7, 4'b1110, 8'hB0);
        addv(DG, 4'hF, 4'h0, 4'd15,   8, 4'b1111, 8'hFF);
        addv(DG, 4'hF, 4'h0, 4'd15,  10, 4'b1101, 8'hA4);
        addv(DG, 4'hF, 4'h0, 4'd15,  18, 4'b1011, 8'hF9);
        addv(DG, 4'hF, 4'h0, 4'd15,  26, 4'b0111, 8'hC0);
        addv(DG, 4'hF, 4'h0, 4'd15,  34, 4'b1110, 8'hB0);
        addv(DG, 4'hB, 4'h0, 4'd15,  18, 4'b1111, 8'hF9);
        addv(DG, 4'hB, 4'h0, 4'd15,  23, 4'b1111, 8'hF9);
        addv(DG, 4'hB, 4'h0, 4'd15,  26, 4'b0111, 8'hC0);
        addv(DG, 4'hF, 4'h1, 4'd15,  34, 4'b1110, 8'hB0);
        addv(DG, 4'hF, 4'h1, 4'd15,  66, 4'b1111, 8'hB0);
        addv(DG, 4'hF, 4'h1, 4'd15,  74, 4'b1101, 8'hA4);
        addv(DG, 4'hF, 4'h1, 4'd15,  98, 4'b1111, 8'hB0);
        addv(DG, 4'hF, 4'h1, 4'd15, 130, 4'b1110, 8'hB0);
        addv(DG, 4'hF, 4'h0, 4'd3,    2, 4'b1110, 8'hB0);
        addv(DG, 4'hF, 4'h0, 4'd3,    3, 4'b1110, 8'hB0);
        addv(DG, 4'hF, 4'h0, 4'd3,    4, 4'b1111, 8'hB0);
        addv(DG, 4'hF, 4'h0, 4'd0,    2, 4'b1111, 8'hB0);
        addv(DG, 4'hF, 4'h0, 4'd0,   18, 4'b1111, 8'hF9);
        addv(DG, 4'hF, 4'h0, 4'd2,    2, 4'b1110, 8'hB0);
        addv(DG, 4'hF, 4'h0, 4'd2,   11, 4'b1111, 8'hA4);

        foreach (tbl[i]) begin
            digits     = tbl[i].dg;
            digit_en   = tbl[i].den;
            blink_en   = tbl[i].ben;
            brightness = tbl[i].br;
            do_reset();
            step_to(tbl[i].cyc);
            chk($sformatf("vec%0d", i), tbl[i].an, tbl[i].cat);
        end

        // mid-slot pattern change is held off until the next digit-0 slot
        digits = DG; digit_en = 4'hF; blink_en = 4'h0; brightness = 4'd15;
        do_reset();
        step_to(3);
        digits = 32'hC0F9A480;
        step_to(4);
        chk("midslot_s4", 4'b1110, 8'hB0);
        step_to(7);
        chk("midslot_s7", 4'b1110, 8'hB0);
        step_to(10);
        chk("midslot_d1", 4'b1101, 8'hA4);
        step_to(34);
        chk("midslot_next", 4'b1110, 8'h80);

        // one-cycle reset at s=5 of digit 2
        digits = DG;
        do_reset();
        step_to(20);
        chk("prerst_d2", 4'b1011, 8'hF9);
        rst = 1'b1;
        step();
        chk("rst_dark", 4'b1111, 8'hFF);
        rst = 1'b0;
        cur = -1;
        step_to(1);
        chk("postrst_blank", 4'b1111, 8'hFF);
        step_to(2);
        chk("postrst_d0", 4'b1110, 8'hB0);

        // random traffic checked only by the scoreboard
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ((k % 5) == 0) digits = $urandom;
            if ((k % 37) == 0) digit_en = 4'($urandom);
            if ((k % 53) == 0) blink_en = 4'($urandom);
            if ((k % 29) == 0) brightness = 4'($urandom);
            step();
        end

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
